// File: rtl/envelope_pkg.sv
// Shared envelope definitions: state encodings and the unity-gain envelope level
// that downstream multiplier users must agree on.
package envelope_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Multiplier scales by 2^-(BITSIZE-2), so this level is unity gain.
  function automatic int unsigned env_max(input int unsigned bitsize);
    return 32'd1 << (bitsize - 2);
  endfunction

endpackage

// File: rtl/env_sat_step.sv
// Combinational saturating step of the envelope accumulator toward a bound,
// upward (add, clamp at bound) or downward (subtract, clamp at bound).
module env_sat_step #(
  parameter int AW = 23,
  parameter int SW = 16
) (
  input  logic [AW-1:0] i_acc,
  input  logic [SW-1:0] i_step,
  input  logic [AW-1:0] i_bound,
  input  logic          i_dir,
  output logic [AW-1:0] o_nxt,
  output logic          o_reached
);

  logic [AW:0] w_step_ext;
  logic [AW:0] w_sum;
  logic [AW:0] w_diff;

  // One extra bit: carry out on the add, borrow on the subtract.
  assign w_step_ext = {{(AW+1-SW){1'b0}}, i_step};
  assign w_sum      = {1'b0, i_acc} + w_step_ext;
  assign w_diff     = {1'b0, i_acc} - w_step_ext;

  always_comb begin
    o_nxt     = i_bound;
    o_reached = 1'b1;
    if (i_step != '0) begin
      if (i_dir) begin
        if (w_sum < {1'b0, i_bound}) begin
          o_nxt     = w_sum[AW-1:0];
          o_reached = 1'b0;
        end
      end else if (!w_diff[AW] && (w_diff[AW-1:0] > i_bound)) begin
        o_nxt     = w_diff[AW-1:0];
        o_reached = 1'b0;
      end
    end
  end

endmodule

// File: rtl/envelope_generator.sv
// Per-voice ADSR envelope generator; advances once per sample_tick and produces
// the signed gain operand for the downstream fractional multiplier.
module envelope_generator
  import envelope_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int RATEBITS = 16,
  parameter int FRAC     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic                       gate,
  input  logic        [RATEBITS-1:0] attack_step,
  input  logic        [RATEBITS-1:0] decay_step,
  input  logic        [BITSIZE-2:0]  sustain_level,
  input  logic        [RATEBITS-1:0] release_step,
  output logic signed [BITSIZE-1:0]  env,
  output logic        [2:0]          state,
  output logic                       active
);

  localparam int AW = BITSIZE - 1 + FRAC;
  localparam logic [BITSIZE-2:0] ENV_MAX = (BITSIZE-1)'(env_max(BITSIZE));
  localparam logic [AW-1:0]      ACC_MAX = {ENV_MAX, {FRAC{1'b0}}};

  env_state_t                 r_state;
  logic        [AW-1:0]       r_acc;
  logic signed [BITSIZE-1:0]  r_env;
  logic                       r_active;
  logic                       r_gate_prev;

  logic        [BITSIZE-2:0]  w_sus_lvl;
  logic        [AW-1:0]       w_sus_acc;
  logic                       w_rise;
  logic                       w_fall;
  logic        [RATEBITS-1:0] w_step;
  logic        [AW-1:0]       w_bound;
  logic                       w_dir;
  logic        [AW-1:0]       w_nxt;
  logic                       w_reached;

  function automatic logic signed [BITSIZE-1:0] acc_to_env(input logic [AW-1:0] a);
    return $signed({1'b0, a[AW-1:FRAC]});
  endfunction

  assign w_sus_lvl = (sustain_level > ENV_MAX) ? ENV_MAX : sustain_level;
  assign w_sus_acc = {w_sus_lvl, {FRAC{1'b0}}};
  assign w_rise    = gate & ~r_gate_prev;
  assign w_fall    = ~gate & r_gate_prev;

  always_comb begin
    w_step  = release_step;
    w_bound = '0;
    w_dir   = 1'b0;
    case (r_state)
      ATTACK: begin
        w_step  = attack_step;
        w_bound = ACC_MAX;
        w_dir   = 1'b1;
      end
      DECAY: begin
        w_step  = decay_step;
        w_bound = w_sus_acc;
      end
      default: ;
    endcase
  end

  env_sat_step #(.AW(AW), .SW(RATEBITS)) u_step (
    .i_acc     (r_acc),
    .i_step    (w_step),
    .i_bound   (w_bound),
    .i_dir     (w_dir),
    .o_nxt     (w_nxt),
    .o_reached (w_reached)
  );

  // Transitions triggered by a gate edge leave the accumulator untouched that tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_env       <= '0;
      r_active    <= 1'b0;
      r_gate_prev <= 1'b0;
    end else if (sample_tick) begin
      r_gate_prev <= gate;
      case (r_state)
        IDLE: begin
          r_acc <= '0;
          r_env <= '0;
          if (w_rise) begin
            r_state  <= ATTACK;
            r_active <= 1'b1;
          end
        end
        ATTACK: begin
          if (w_fall) begin
            r_state <= RELEASE;
          end else begin
            r_acc <= w_nxt;
            r_env <= acc_to_env(w_nxt);
            if (w_reached) r_state <= DECAY;
          end
        end
        DECAY: begin
          if (w_fall) begin
            r_state <= RELEASE;
          end else begin
            r_acc <= w_nxt;
            r_env <= acc_to_env(w_nxt);
            if (w_reached) r_state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (w_fall) begin
            r_state <= RELEASE;
          end else begin
            r_acc <= w_sus_acc;
            r_env <= acc_to_env(w_sus_acc);
          end
        end
        RELEASE: begin
          if (w_rise) begin
            r_state <= ATTACK;
          end else begin
            r_acc <= w_nxt;
            r_env <= acc_to_env(w_nxt);
            if (w_reached) begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign env    = r_env;
  assign state  = r_state;
  assign active = r_active;

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: a behavioural ADSR model pushes the
// expected env/state/active for every tick, popped after the DUT updates.
module tb_envelope_generator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_tick = 1'b0;
  logic               gate = 1'b0;
  logic        [15:0] attack_step = '0;
  logic        [15:0] decay_step = '0;
  logic        [14:0] sustain_level = '0;
  logic        [15:0] release_step = '0;
  logic signed [15:0] env;
  logic        [2:0]  state;
  logic               active;

  envelope_generator #(.BITSIZE(16), .RATEBITS(16), .FRAC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .env           (env),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int env;
    int st;
    int act;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_acc = 0;
  int   m_st  = 0;
  bit   m_gp  = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference ADSR: acc in units of 1/256 env LSB, states 0..4.
  task automatic model_step();
    int  accmax;
    int  s;
    int  t;
    bit  rise;
    bit  fall;
    accmax = 16384 * 256;
    s      = ((int'(sustain_level) > 16384) ? 16384 : int'(sustain_level)) * 256;
    rise   = gate && !m_gp;
    fall   = !gate && m_gp;
    m_gp   = gate;
    case (m_st)
      0: begin
        m_acc = 0;
        if (rise) m_st = 1;
      end
      1: begin
        if (fall) m_st = 4;
        else begin
          t = m_acc + int'(attack_step);
          m_acc = (attack_step == 0 || t > accmax) ? accmax : t;
          if (m_acc == accmax) m_st = 2;
        end
      end
      2: begin
        if (fall) m_st = 4;
        else begin
          t = m_acc - int'(decay_step);
          m_acc = (decay_step == 0 || t < s) ? s : t;
          if (m_acc == s) m_st = 3;
        end
      end
      3: begin
        if (fall) m_st = 4;
        else m_acc = s;
      end
      default: begin
        if (rise) m_st = 1;
        else begin
          t = m_acc - int'(release_step);
          m_acc = (release_step == 0 || t < 0) ? 0 : t;
          if (m_acc == 0) m_st = 0;
        end
      end
    endcase
  endtask

  task automatic tick(input string tag);
    exp_t e;
    exp_t g;
    sample_tick = 1'b1;
    model_step();
    e.env = m_acc / 256;
    e.st  = m_st;
    e.act = (m_st != 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    g = sb.pop_front();
    chk({tag, "_env"}, int'(env), g.env);
    chk({tag, "_state"}, int'(state), g.st);
    chk({tag, "_active"}, int'(active), g.act);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_env"}, int'(env), g.env);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0;
    m_st  = 0;
    m_gp  = 1'b0;
    sb.delete();
    chk("rst_env", int'(env), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_active", int'(active), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of an attack
    attack_step = 16'h4000;
    gate = 1'b1;
    tick("rise0");
    repeat (5) tick("atk0");
    chk("pre_rst_env", int'(env), 320);
    do_reset();
    gate = 1'b0;
    repeat (3) tick("idle_after_rst");
    chk("idle_after_rst_env", int'(env), 0);

    // Full attack / decay / sustain / release
    decay_step    = 16'h2000;
    sustain_level = 15'd8192;
    release_step  = 16'h1000;
    gate = 1'b1;
    tick("rise1");
    chk("rise1_env", int'(env), 0);
    n = 0;
    while (state == 3'd1 && n < 300) begin
      tick("atk1");
      n++;
    end
    chk("atk_ticks", n, 256);
    chk("peak_env", int'(env), 16384);
    chk("peak_state", int'(state), 2);
    n = 0;
    while (state == 3'd2 && n < 300) begin
      tick("dec1");
      n++;
    end
    chk("dec_ticks", n, 256);
    chk("sus_env", int'(env), 8192);
    chk("sus_state", int'(state), 3);
    sustain_level = 15'd4000;
    tick("sus_live");
    chk("sus_live_env", int'(env), 4000);
    sustain_level = 15'd8192;
    tick("sus_back");
    chk("sus_back_env", int'(env), 8192);
    gate = 1'b0;
    tick("fall1");
    chk("fall1_state", int'(state), 4);
    chk("fall1_env", int'(env), 8192);
    n = 0;
    while (state == 3'd4 && n < 600) begin
      tick("rel1");
      n++;
    end
    chk("rel_ticks", n, 512);
    chk("rel_end_env", int'(env), 0);
    chk("rel_end_active", int'(active), 0);

    // Legato retrigger from RELEASE at 5000
    attack_step   = 16'h0000;
    decay_step    = 16'h0000;
    sustain_level = 15'd5000;
    gate = 1'b1;
    tick("rise2");
    tick("peak2");
    tick("sus2");
    gate = 1'b0;
    tick("fall2");
    chk("fall2_env", int'(env), 5000);
    attack_step = 16'h4000;
    gate = 1'b1;
    tick("retrig");
    chk("retrig_state", int'(state), 1);
    chk("retrig_env", int'(env), 5000);
    tick("retrig_atk");
    chk("retrig_next_env", int'(env), 5064);
    gate = 1'b0;
    release_step = 16'h0000;
    tick("fall3");
    tick("rel3");
    chk("rel3_state", int'(state), 0);

    // Zero steps: each phase completes in one tick
    attack_step   = 16'h0000;
    sustain_level = 15'd8192;
    gate = 1'b1;
    tick("rise4");
    tick("z_atk");
    chk("z_atk_env", int'(env), 16384);
    tick("z_dec");
    chk("z_dec_env", int'(env), 8192);
    gate = 1'b0;
    tick("z_fall");
    tick("z_rel");
    chk("z_rel_env", int'(env), 0);
    chk("z_rel_active", int'(active), 0);

    // Fall beats peak on the same tick
    gate = 1'b1;
    tick("rise5");
    gate = 1'b0;
    tick("fall_vs_peak");
    chk("fall_vs_peak_state", int'(state), 4);
    chk("fall_vs_peak_env", int'(env), 0);
    tick("rel5");

    // Fall right at peak: env holds 16384 in RELEASE
    gate = 1'b1;
    tick("rise6");
    tick("peak6");
    gate = 1'b0;
    tick("fall6");
    chk("fall6_env", int'(env), 16384);
    chk("fall6_state", int'(state), 4);
    tick("rel6");

    // Continuous sample_tick advances every clk
    attack_step = 16'h4000;
    gate = 1'b1;
    sample_tick = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sample_tick = 1'b0;
    chk("cont_tick_env", int'(env), 192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
